// File: rtl/zorro_slave_cycle_if.sv
// Zorro slave-side bus signals seen by one expansion board, plus the local
// target request/acknowledge pair that the slave cycle controller drives.
interface zorro_slave_cycle_if;
  logic FCS_n;
  logic ADDR_MATCH;
  logic READ;
  logic DOE;
  logic MYBUS;
  logic LOCAL_ACK;
  logic SLAVE_n;
  logic DTACK_n;
  logic LOCAL_REQ;
  logic LOCAL_RW;
  logic TIMEOUT;

  modport slave (
    input  FCS_n, ADDR_MATCH, READ, DOE, MYBUS, LOCAL_ACK,
    output SLAVE_n, DTACK_n, LOCAL_REQ, LOCAL_RW, TIMEOUT
  );

  modport master (
    output FCS_n, ADDR_MATCH, READ, DOE, MYBUS, LOCAL_ACK,
    input  SLAVE_n, DTACK_n, LOCAL_REQ, LOCAL_RW, TIMEOUT
  );
endinterface

// File: rtl/zorro_slave_cycle.sv
// Zorro slave cycle controller: detects a full-cycle strobe aimed at this board,
// runs the local access and generates SLAVE_n/DTACK_n with a forced-DTACK timeout.
module zorro_slave_cycle #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  zorro_slave_cycle_if.slave   zorro,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       fcs_q;
  logic       fcs_d;
  logic       armed;
  logic       start;
  logic       slave_n;
  logic       dtack_n;
  logic       local_req;
  logic       local_rw;
  logic       timeout;

  // armed stays low after reset until FCS_n has really been sampled high, so a
  // strobe already low when reset releases cannot look like a fresh falling edge.
  assign start = armed && !fcs_q && fcs_d;

  // Local handshake: LOCAL_REQ rises on ACCESS entry and is held until the edge
  // on which LOCAL_ACK is seen (or the cycle times out or aborts); LOCAL_ACK is
  // only consumed in ACCESS and ignored in every other state.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      fcs_q     <= 1'b1;
      fcs_d     <= 1'b1;
      armed     <= 1'b0;
      slave_n   <= 1'b1;
      dtack_n   <= 1'b1;
      local_req <= 1'b0;
      local_rw  <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      fcs_q   <= zorro.FCS_n;
      fcs_d   <= fcs_q;
      timeout <= 1'b0;
      if (zorro.FCS_n) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (start && zorro.ADDR_MATCH && !zorro.MYBUS) begin
            state    <= SELECT;
            slave_n  <= 1'b0;
            local_rw <= zorro.READ;
          end
        end
        SELECT: begin
          if (fcs_q) begin
            state   <= IDLE;
            slave_n <= 1'b1;
          end else if (zorro.DOE) begin
            state     <= ACCESS;
            local_req <= 1'b1;
            cnt       <= 8'd0;
          end
        end
        ACCESS: begin
          // Abort wins, then the real acknowledge, then the forced one.
          if (fcs_q) begin
            state     <= IDLE;
            slave_n   <= 1'b1;
            local_req <= 1'b0;
          end else if (zorro.LOCAL_ACK) begin
            state     <= ACK;
            dtack_n   <= 1'b0;
            local_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= ACK;
            dtack_n   <= 1'b0;
            local_req <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK: begin
          if (fcs_q) begin
            state   <= IDLE;
            slave_n <= 1'b1;
            dtack_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zorro.SLAVE_n   = slave_n;
  assign zorro.DTACK_n   = dtack_n;
  assign zorro.LOCAL_REQ = local_req;
  assign zorro.LOCAL_RW  = local_rw;
  assign zorro.TIMEOUT   = timeout;
  assign state_dbg       = state;

endmodule

// File: tb/tb_zorro_slave_cycle.sv
// Directed bench for zorro_slave_cycle: each step drives the bus, queues the
// expected {state, SLAVE_n, DTACK_n, LOCAL_REQ, LOCAL_RW, TIMEOUT} and checks it.
module tb_zorro_slave_cycle;

  localparam int W = 7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic       CLK;
  logic       RESET_n;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;

  zorro_slave_cycle_if zorro ();

  zorro_slave_cycle #(.TIMEOUT_CYCLES(4)) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .zorro     (zorro),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [1:0] st, input logic s, input logic d,
                                      input logic r, input logic rw, input logic t);
    return {st, s, d, r, rw, t};
  endfunction

  task automatic chk(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {state_dbg, zorro.SLAVE_n, zorro.DTACK_n, zorro.LOCAL_REQ, zorro.LOCAL_RW, zorro.TIMEOUT};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %b, no expected entry queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic fcs, input logic am, input logic rd,
                       input logic doe, input logic mb, input logic ack);
    zorro.FCS_n      = fcs;
    zorro.ADDR_MATCH = am;
    zorro.READ       = rd;
    zorro.DOE        = doe;
    zorro.MYBUS      = mb;
    zorro.LOCAL_ACK  = ack;
  endtask

  // Called just after a falling edge; covers exactly one rising edge.
  task automatic step(input logic fcs, input logic am, input logic rd, input logic doe,
                      input logic mb, input logic ack, input logic [W-1:0] exp, input string tag);
    drive(fcs, am, rd, doe, mb, ack);
    exp_q.push_back(exp);
    @(negedge CLK);
    chk(tag);
  endtask

  // Random bus noise with FCS_n high: nothing may start or change.
  task automatic idle_gap(input logic rw);
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ev(S_IDLE, 1, 1, 0, rw, 0), "idle_gap");
  endtask

  // ---------------- invariants ----------------
  always @(negedge CLK) begin
    if (RESET_n === 1'b1) begin
      n_vec++;
      assert (!(zorro.DTACK_n === 1'b0 && zorro.SLAVE_n !== 1'b0)) else begin
        n_err++;
        $error("FAIL inv_dtack_slave: DTACK_n=%b SLAVE_n=%b", zorro.DTACK_n, zorro.SLAVE_n);
      end
      n_vec++;
      assert (!(zorro.LOCAL_REQ === 1'b1 && state_dbg !== S_ACCESS)) else begin
        n_err++;
        $error("FAIL inv_req_access: LOCAL_REQ=%b state=%0d", zorro.LOCAL_REQ, state_dbg);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    RESET_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0);

    // reset state
    @(negedge CLK);
    exp_q.push_back(ev(S_IDLE, 1, 1, 0, 1, 0));
    chk("reset");
    RESET_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "idle_arm");

    // read hit: SLAVE_n after edge 1, LOCAL_REQ after edge 2, DTACK_n after edge 4
    step(0, 1, 1, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rd_e0");
    step(0, 1, 1, 1, 0, 0, ev(S_SELECT, 0, 1, 0, 1, 0), "rd_e1_select");
    step(0, 1, 1, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "rd_e2_access");
    step(0, 1, 1, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "rd_e3_wait");
    step(0, 1, 1, 1, 0, 1, ev(S_ACK,    0, 0, 0, 1, 0), "rd_e4_dtack");
    step(0, 1, 1, 1, 0, 0, ev(S_ACK,    0, 0, 0, 1, 0), "rd_ack_hold");
    step(1, 1, 1, 1, 0, 0, ev(S_ACK,    0, 0, 0, 1, 0), "rd_fcs_sampled");
    step(1, 1, 1, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rd_release");
    idle_gap(1'b1);

    // miss, refusal, and no re-arm while FCS_n stays low
    step(0, 0, 1, 1, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "miss_e0");
    step(0, 0, 1, 1, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "miss_start");
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "miss_no_rearm");
    step(1, 0, 0, 0, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "miss_fcs_hi");
    step(1, 0, 0, 0, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "miss_fcs_hi2");
    step(0, 1, 0, 1, 1, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "refuse_e0");
    step(0, 1, 0, 1, 1, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "refuse_start");
    step(0, 1, 0, 1, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "refuse_no_rearm");
    step(1, 0, 0, 0, 0, 0, ev(S_IDLE, 1, 1, 0, 1, 0), "refuse_fcs_hi");
    idle_gap(1'b1);

    // write selected, then aborted in SELECT
    step(0, 1, 0, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "abs_e0");
    step(0, 1, 0, 0, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "abs_select_wr");
    step(0, 1, 0, 0, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "abs_wait_doe");
    step(1, 1, 0, 0, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "abs_fcs_sampled");
    step(1, 1, 0, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 0, 0), "abs_idle");
    idle_gap(1'b0);

    // timeout; LOCAL_ACK ignored before ACCESS; MYBUS rise does not abort
    step(0, 1, 1, 0, 0, 1, ev(S_IDLE,   1, 1, 0, 0, 0), "to_e0_ack_ign");
    step(0, 1, 1, 0, 0, 1, ev(S_SELECT, 0, 1, 0, 1, 0), "to_select");
    step(0, 1, 1, 0, 1, 1, ev(S_SELECT, 0, 1, 0, 1, 0), "to_mybus_hold");
    step(0, 1, 1, 1, 1, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "to_access");
    step(0, 1, 1, 1, 1, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "to_cnt1");
    step(0, 1, 1, 1, 1, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "to_cnt2");
    step(0, 1, 1, 1, 1, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "to_cnt3");
    step(0, 1, 1, 1, 1, 0, ev(S_ACK,    0, 0, 0, 1, 1), "to_forced_dtack");
    step(0, 1, 1, 1, 1, 0, ev(S_ACK,    0, 0, 0, 1, 0), "to_pulse_end");
    step(1, 1, 1, 1, 0, 0, ev(S_ACK,    0, 0, 0, 1, 0), "to_fcs_sampled");
    step(1, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "to_idle");
    idle_gap(1'b1);

    // tie: LOCAL_ACK exactly at the last count wins, no TIMEOUT
    step(0, 1, 0, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "tie_e0");
    step(0, 1, 0, 1, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "tie_select");
    step(0, 1, 0, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 0, 0), "tie_access");
    step(0, 1, 0, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 0, 0), "tie_cnt1");
    step(0, 1, 0, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 0, 0), "tie_cnt2");
    step(0, 1, 0, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 0, 0), "tie_cnt3");
    step(0, 1, 0, 1, 0, 1, ev(S_ACK,    0, 0, 0, 0, 0), "tie_ack_no_to");
    step(1, 1, 0, 1, 0, 0, ev(S_ACK,    0, 0, 0, 0, 0), "tie_fcs_sampled");
    step(1, 1, 0, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 0, 0), "tie_idle");
    idle_gap(1'b0);

    // abort in ACCESS: LOCAL_REQ drops, DTACK_n never asserted
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 0, 0), "aba_e0");
    step(0, 1, 1, 1, 0, 0, ev(S_SELECT, 0, 1, 0, 1, 0), "aba_select");
    step(0, 1, 1, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "aba_access");
    step(1, 1, 1, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "aba_fcs_sampled");
    step(1, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "aba_idle");
    idle_gap(1'b1);

    // reset during ACK with FCS_n low
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_e0");
    step(0, 1, 1, 1, 0, 0, ev(S_SELECT, 0, 1, 0, 1, 0), "rst_select");
    step(0, 1, 1, 1, 0, 0, ev(S_ACCESS, 0, 1, 1, 1, 0), "rst_access");
    step(0, 1, 1, 1, 0, 1, ev(S_ACK,    0, 0, 0, 1, 0), "rst_ack");
    zorro.LOCAL_ACK = 1'b0;
    RESET_n = 1'b0;
    #1;
    exp_q.push_back(ev(S_IDLE, 1, 1, 0, 1, 0));
    chk("rst_async");
    @(negedge CLK);
    exp_q.push_back(ev(S_IDLE, 1, 1, 0, 1, 0));
    chk("rst_hold");
    RESET_n = 1'b1;
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_low_1");
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_low_2");
    step(0, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_low_3");
    step(1, 1, 1, 1, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_fcs_hi");
    step(0, 1, 0, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 1, 0), "rst_rearm_e0");
    step(0, 1, 0, 0, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "rst_rearm_select");
    step(1, 1, 0, 0, 0, 0, ev(S_SELECT, 0, 1, 0, 0, 0), "rst_end_sampled");
    step(1, 1, 0, 0, 0, 0, ev(S_IDLE,   1, 1, 0, 0, 0), "rst_end_idle");

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drain: observed %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zorro_slave_cycle.md
ZORRO_SLAVE_CYCLE -- requirements
Module: zorro_slave_cycle

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 64, meaning the cycles allowed in ACCESS before a forced DTACK (legal range 2..255).
REQ-002 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 RESET_n  input  1  reset, asynchronous and active-low.
REQ-004 FCS_n  input  1  Zorro full-cycle strobe, active low.
REQ-005 ADDR_MATCH  input  1  the board's address decode hit for the current cycle.
REQ-006 READ  input  1  Zorro direction; 1 means a read.
REQ-007 DOE  input  1  Zorro data output enable.
REQ-008 MYBUS  input  1  the board owns the bus as master; slave cycles are refused while it is high.
REQ-009 LOCAL_ACK  input  1  the local target has completed the access.
REQ-010 SLAVE_n  output  1  the board is selected as slave, active low; feeds buffer control.
REQ-011 DTACK_n  output  1  Zorro data transfer acknowledge, active low; feeds buffer control.
REQ-012 LOCAL_REQ  output  1  access request to the local target.
REQ-013 LOCAL_RW  output  1  latched READ for the local target.
REQ-014 TIMEOUT  output  1  one-cycle pulse when an access is force-terminated.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FCS_n SHALL pass through one register stage (fcs_q), with a second register (fcs_d) holding the prior fcs_q.
REQ-017 Start is defined as fcs_q=0 and fcs_d=1.
REQ-018 The state machine SHALL have the states IDLE, SELECT, ACCESS, ACK.
REQ-019 IDLE -> SELECT on start with ADDR_MATCH=1 and MYBUS=0; on that edge SLAVE_n<=0 and LOCAL_RW<=READ.
- SLAVE_n therefore falls on the second rising edge at which FCS_n is sampled low.
REQ-020 Start with ADDR_MATCH=0 or MYBUS=1 SHALL leave the block in IDLE with no output change.
- The cycle is not re-armed until FCS_n returns high (edge detect).
REQ-021 SELECT -> ACCESS on DOE=1 with fcs_q=0; on that edge LOCAL_REQ<=1 and the counter clears to 0.
REQ-022 In ACCESS the 8-bit counter SHALL increment once per cycle.
REQ-023 ACCESS -> ACK on LOCAL_ACK=1; on that edge DTACK_n<=0 and LOCAL_REQ<=0.
REQ-024 ACCESS -> ACK when counter==TIMEOUT_CYCLES-1 and LOCAL_ACK=0; on that edge DTACK_n<=0, LOCAL_REQ<=0 and TIMEOUT<=1 for exactly one cycle.
REQ-025 LOCAL_ACK SHALL take priority over timeout in the same cycle, with no TIMEOUT pulse.
REQ-026 In ACK, DTACK_n and SLAVE_n SHALL stay low until fcs_q=1; on that edge go to IDLE with SLAVE_n<=1 and DTACK_n<=1 together.
REQ-027 fcs_q=1 in SELECT or ACCESS (aborted cycle) SHALL return to IDLE on that edge with SLAVE_n<=1 and LOCAL_REQ<=0.
- DTACK_n is never asserted and no TIMEOUT pulse occurs.
REQ-028 LOCAL_ACK outside ACCESS SHALL be ignored.
REQ-029 MYBUS rising while the block is in a slave state SHALL NOT abort the cycle; only FCS_n terminates it.
REQ-030 DTACK_n=0 SHALL imply SLAVE_n=0 in every cycle.
REQ-031 LOCAL_REQ=1 SHALL occur only in ACCESS.

Reset
REQ-032 While RESET_n=0, asynchronously: state IDLE, counter 0, fcs_q=fcs_d=1, SLAVE_n=1, DTACK_n=1, LOCAL_REQ=0, LOCAL_RW=1, TIMEOUT=0.
REQ-033 Reset asserted mid-cycle SHALL immediately release SLAVE_n, DTACK_n and LOCAL_REQ.
REQ-034 After RESET_n rises with FCS_n already low, no cycle SHALL start until FCS_n has been sampled high and then low again.

Verification
REQ-035 Read hit: FCS_n low at edge 0, ADDR_MATCH=1, READ=1, MYBUS=0, DOE=1 from edge 1, LOCAL_ACK high at edge 4 -> SLAVE_n low after edge 1, LOCAL_REQ high after edge 2, DTACK_n low after edge 4, both release one edge after FCS_n is sampled high.
REQ-036 Miss and refusal: ADDR_MATCH=0 on one cycle, then ADDR_MATCH=1 with MYBUS=1 on the next -> SLAVE_n, DTACK_n and LOCAL_REQ never change.
REQ-037 Timeout: TIMEOUT_CYCLES=4, LOCAL_ACK held 0 -> DTACK_n falls on the 4th edge after ACCESS entry with a single TIMEOUT pulse; the FCS_n rise then returns the block to IDLE.
REQ-038 Tie: LOCAL_ACK=1 exactly at counter==TIMEOUT_CYCLES-1 -> DTACK_n=0 and TIMEOUT stays 0.
REQ-039 Abort: FCS_n rises while in SELECT (DOE=0) -> IDLE, SLAVE_n=1, DTACK_n never asserted, LOCAL_REQ never asserted.
REQ-040 Reset mid-ACK: RESET_n pulsed low while DTACK_n=0 and FCS_n low -> all outputs return to reset values immediately; no new cycle starts until FCS_n goes high and then low again.
